// File: rtl/parameters.sv
// rtl/parameters.sv - shared sizing constants and types for the rename free list
//   PHYS_REGS            : physical register count (power of two)
//   PHYS_REGS_ADDR_WIDTH : bits needed to name one physical register
//   DISPATCH_WIDTH       : allocation lanes per cycle
//   COMMIT_WIDTH         : release lanes per cycle
//   NUM_CKPT             : read-pointer checkpoint slots
//   ckpt_id_t            : checkpoint slot selector
package parameters;
  localparam int PHYS_REGS            = 64;
  localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
  localparam int DISPATCH_WIDTH       = 2;
  localparam int COMMIT_WIDTH         = 2;
  localparam int NUM_CKPT             = 4;

  typedef logic [$clog2(NUM_CKPT)-1:0] ckpt_id_t;
endpackage

// File: rtl/freelistIf.sv
// rtl/freelistIf.sv - bundle of free-list signals between rename, commit and recovery
//   pop_en/pop_ready/pop_reg        : allocation side (rename)
//   push_en/push_reg                : release side (commit)
//   ckpt_save*/ckpt_restore*        : branch checkpoint save and recovery
//   num_free/overflow               : occupancy and sticky release error
interface freelistIf
  import parameters::*;
#(
  parameter int POP_W  = DISPATCH_WIDTH,
  parameter int PUSH_W = COMMIT_WIDTH,
  parameter int AW     = PHYS_REGS_ADDR_WIDTH
);
  logic [POP_W-1:0]           pop_en;
  logic                       pop_ready;
  logic [POP_W-1:0][AW-1:0]   pop_reg;
  logic [PUSH_W-1:0]          push_en;
  logic [PUSH_W-1:0][AW-1:0]  push_reg;
  logic                       ckpt_save;
  ckpt_id_t                   ckpt_save_id;
  logic                       ckpt_restore;
  ckpt_id_t                   ckpt_restore_id;
  logic [AW:0]                num_free;
  logic                       overflow;

  modport rename (output pop_en, input pop_ready, input pop_reg, input num_free);
  modport commit (output push_en, output push_reg, input overflow);
  modport recovery (output ckpt_save, output ckpt_save_id,
                    output ckpt_restore, output ckpt_restore_id);
endinterface

// File: rtl/lane_rank.sv
// rtl/lane_rank.sv - per-lane prefix count of enabled lanes, plus total
//   en    : lane enable mask
//   rank  : number of enabled lanes strictly below each lane
//   total : popcount of en
module lane_rank #(
  parameter int W = 2,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]             en,
  output logic [W-1:0][CNT_W-1:0]  rank,
  output logic [CNT_W-1:0]         total
);
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      rank[i] = acc;
      acc     = acc + CNT_W'(en[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - multi-lane physical register free list with read-pointer checkpoints
//   clk, rst                   : clock, synchronous active-high reset
//   pop_en / pop_ready         : allocation request mask / enough free entries for it
//   pop_reg                    : allocated register per lane (valid on a granted pop)
//   push_en / push_reg         : release request mask / released register per lane
//   ckpt_save, ckpt_save_id    : snapshot post-pop tail into a slot
//   ckpt_restore, ckpt_restore_id : roll tail back to a slot (suppresses that cycle's pop)
//   num_free                   : head - tail
//   overflow                   : sticky, set by a release that would overfill the list
module freelist_ckpt
  import parameters::*;
#(
  parameter int NUM_REGS = PHYS_REGS,
  parameter int POP_W    = DISPATCH_WIDTH,
  parameter int PUSH_W   = COMMIT_WIDTH,
  parameter int NUM_CKPT = parameters::NUM_CKPT,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int PW      = AW + 1,
  localparam int CW      = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [POP_W-1:0]           pop_en,
  output logic                       pop_ready,
  output logic [POP_W-1:0][AW-1:0]   pop_reg,
  input  logic [PUSH_W-1:0]          push_en,
  input  logic [PUSH_W-1:0][AW-1:0]  push_reg,
  input  logic                       ckpt_save,
  input  logic [CW-1:0]              ckpt_save_id,
  input  logic                       ckpt_restore,
  input  logic [CW-1:0]              ckpt_restore_id,
  output logic [PW-1:0]              num_free,
  output logic                       overflow
);
  localparam int PCW = $clog2(POP_W + 1);
  localparam int SCW = $clog2(PUSH_W + 1);

  logic [AW-1:0] queue [NUM_REGS];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] ckpt [NUM_CKPT];

  logic [POP_W-1:0][PCW-1:0]  pop_rank;
  logic [PCW-1:0]             pop_cnt;
  logic [PUSH_W-1:0][SCW-1:0] push_rank;
  logic [SCW-1:0]             push_cnt;

  lane_rank #(.W(POP_W)) u_pop_rank (
    .en    (pop_en),
    .rank  (pop_rank),
    .total (pop_cnt)
  );

  lane_rank #(.W(PUSH_W)) u_push_rank (
    .en    (push_en),
    .rank  (push_rank),
    .total (push_cnt)
  );

  logic          pop_grant;
  logic          push_ok;
  logic          push_accept;
  logic          push_reject;
  logic [PW-1:0] tail_next;

  assign num_free  = head - tail;
  // Occupancy is taken at cycle start; a same-cycle release never feeds a pop.
  assign pop_ready = num_free >= PW'(pop_cnt);
  assign pop_grant = (|pop_en) && pop_ready && !ckpt_restore;

  // One extra bit so the sum cannot wrap before the capacity compare.
  assign push_ok     = ({1'b0, num_free} + (PW+1)'(push_cnt)) <= (PW+1)'(NUM_REGS - 1);
  assign push_accept = (|push_en) && push_ok;
  assign push_reject = (|push_en) && !push_ok;

  assign tail_next = pop_grant ? tail + PW'(pop_cnt) : tail;

  always_comb begin
    for (int i = 0; i < POP_W; i++) begin
      logic [PW-1:0] rd_ptr;
      rd_ptr     = tail + PW'(pop_rank[i]);
      pop_reg[i] = queue[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Register 0 sits at index 0 but tail starts at 1, so it is never handed out.
      for (int i = 0; i < NUM_REGS; i++) begin
        queue[i] <= AW'(i);
      end
      for (int j = 0; j < NUM_CKPT; j++) begin
        ckpt[j] <= PW'(1);
      end
      tail     <= PW'(1);
      head     <= PW'(NUM_REGS);
      overflow <= 1'b0;
    end else begin
      if (push_accept) begin
        for (int i = 0; i < PUSH_W; i++) begin
          if (push_en[i]) begin
            logic [PW-1:0] wr_ptr;
            wr_ptr                 = head + PW'(push_rank[i]);
            queue[wr_ptr[AW-1:0]] <= push_reg[i];
          end
        end
        head <= head + PW'(push_cnt);
      end
      if (push_reject) begin
        overflow <= 1'b1;
      end
      if (ckpt_restore) begin
        tail <= ckpt[ckpt_restore_id];
      end else begin
        tail <= tail_next;
        if (ckpt_save) begin
          ckpt[ckpt_save_id] <= tail_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - directed table, drain/overflow sequences and random wrap scoreboard for freelist_ckpt
module tb_freelist_ckpt;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       pop_en;
  logic             pop_ready;
  logic [1:0][5:0]  pop_reg;
  logic [1:0]       push_en;
  logic [1:0][5:0]  push_reg;
  logic             ckpt_save;
  logic [1:0]       ckpt_save_id;
  logic             ckpt_restore;
  logic [1:0]       ckpt_restore_id;
  logic [6:0]       num_free;
  logic             overflow;

  int tests  = 0;
  int failed = 0;

  freelist_ckpt #(.NUM_REGS(64), .POP_W(2), .PUSH_W(2), .NUM_CKPT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pop_en          (pop_en),
    .pop_ready       (pop_ready),
    .pop_reg         (pop_reg),
    .push_en         (push_en),
    .push_reg        (push_reg),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .num_free        (num_free),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] pop_en;
    logic [1:0] push_en;
    logic [5:0] pr0;
    logic [5:0] pr1;
    logic       save;
    logic [1:0] sid;
    logic       restore;
    logic [1:0] rid;
    logic       chk;
    logic       exp_ready;
    logic [1:0] pop_chk;
    logic [5:0] ep0;
    logic [5:0] ep1;
    logic [6:0] exp_nf;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic [1:0] pe, logic [1:0] se, logic [5:0] p0, logic [5:0] p1,
                              logic sv, logic [1:0] si, logic rs, logic [1:0] ri,
                              logic ck, logic erdy, logic [1:0] pc, logic [5:0] e0, logic [5:0] e1,
                              logic [6:0] enf, logic eovf);
    vec_t v;
    v.rst = r; v.pop_en = pe; v.push_en = se; v.pr0 = p0; v.pr1 = p1;
    v.save = sv; v.sid = si; v.restore = rs; v.rid = ri;
    v.chk = ck; v.exp_ready = erdy; v.pop_chk = pc; v.ep0 = e0; v.ep1 = e1;
    v.exp_nf = enf; v.exp_ovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] pe, input logic [1:0] se,
                       input logic [5:0] p0, input logic [5:0] p1,
                       input logic sv, input logic [1:0] si, input logic rs, input logic [1:0] ri);
    rst = r; pop_en = pe; push_en = se; push_reg[0] = p0; push_reg[1] = p1;
    ckpt_save = sv; ckpt_save_id = si; ckpt_restore = rs; ckpt_restore_id = ri;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt2(input logic [1:0] x);
    return int'(x[0]) + int'(x[1]);
  endfunction

  int fl [$];
  int live [$];

  initial begin
    drive(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step();

    // ---------------- directed table ----------------
    // rst pe se pr0 pr1 sv sid rs rid | chk rdy pchk ep0 ep1 nf ovf
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 0, 0,  0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 63, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b11, 1, 2, 63, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 61, 0));
    // single-lane compaction
    tbl.push_back(mk(1, 2'b11, 2'b01, 7, 0, 1, 1, 0, 0,  0, 0, 2'b00, 0, 0,  0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b10, 0, 1, 63, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 2, 0, 62, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 61, 0));
    // checkpoint save / restore
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 0, 0,  0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b11, 1, 2, 63, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 3, 0, 61, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 1, 2, 0, 0,  1, 1, 2'b00, 0, 0, 60, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b11, 4, 5, 60, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b11, 6, 7, 58, 0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 9, 0, 0, 0, 1, 2,  1, 1, 2'b00, 0, 0, 56, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 61, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 0, 0,  1, 1, 2'b11, 4, 5, 61, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 59, 0));
    // restore slot1 (tail 6) while saving slot2: the save must be dropped
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 1, 2, 1, 1,  1, 1, 2'b00, 0, 0, 59, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 6, 0, 59, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2,  1, 1, 2'b00, 0, 0, 58, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 4, 0, 61, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 60, 0));
    // overflow on a full list
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 0, 0,  0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 5, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 63, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 1, 0, 63, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 62, 1));
    tbl.push_back(mk(0, 2'b01, 2'b10, 0, 1, 0, 0, 0, 0,  1, 1, 2'b01, 2, 0, 62, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  1, 1, 2'b00, 0, 0, 62, 1));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].pop_en, tbl[k].push_en, tbl[k].pr0, tbl[k].pr1,
            tbl[k].save, tbl[k].sid, tbl[k].restore, tbl[k].rid);
      @(negedge clk);
      if (tbl[k].chk) begin
        check($sformatf("v%0d num_free", k), int'(num_free), int'(tbl[k].exp_nf));
        check($sformatf("v%0d pop_ready", k), int'(pop_ready), int'(tbl[k].exp_ready));
        check($sformatf("v%0d overflow", k), int'(overflow), int'(tbl[k].exp_ovf));
        if (tbl[k].pop_chk[0]) check($sformatf("v%0d pop_reg0", k), int'(pop_reg[0]), int'(tbl[k].ep0));
        if (tbl[k].pop_chk[1]) check($sformatf("v%0d pop_reg1", k), int'(pop_reg[1]), int'(tbl[k].ep1));
      end
      step();
    end

    // ---------------- drain to empty ----------------
    drive(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step();
    for (int k = 0; k < 31; k++) begin
      drive(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      @(negedge clk);
      check($sformatf("drain%0d lane0", k), int'(pop_reg[0]), 2 * k + 1);
      check($sformatf("drain%0d lane1", k), int'(pop_reg[1]), 2 * k + 2);
      step();
    end
    @(negedge clk);
    check("drain nf1", int'(num_free), 1);
    check("drain ready11", int'(pop_ready), 0);
    step();
    check("drain nf held", int'(num_free), 1);
    drive(1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("drain ready01", int'(pop_ready), 1);
    check("drain last reg", int'(pop_reg[0]), 63);
    step();
    @(negedge clk);
    check("drain empty nf", int'(num_free), 0);
    check("drain empty ready", int'(pop_ready), 0);
    step();

    // ---------------- random wrap with scoreboard ----------------
    drive(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step();
    fl.delete();
    live.delete();
    for (int r = 1; r < 64; r++) fl.push_back(r);
    for (int c = 0; c < 300; c++) begin
      logic [1:0] pe;
      logic [1:0] se;
      int         pr [2];
      bit         grant;
      pe = 2'($urandom_range(0, 3));
      se = 2'($urandom_range(0, 3));
      if (live.size() < cnt2(se)) se = 2'b00;
      pr[0] = 0;
      pr[1] = 0;
      for (int l = 0; l < 2; l++) begin
        if (se[l]) begin
          int idx;
          idx   = int'($urandom_range(0, live.size() - 1));
          pr[l] = live[idx];
          live.delete(idx);
        end
      end
      drive(1'b0, pe, se, 6'(pr[0]), 6'(pr[1]), 1'b0, 2'd0, 1'b0, 2'd0);
      @(negedge clk);
      grant = (pe != 2'b00) && (fl.size() >= cnt2(pe));
      check($sformatf("rnd%0d num_free", c), int'(num_free), fl.size());
      check($sformatf("rnd%0d pop_ready", c), int'(pop_ready), int'(fl.size() >= cnt2(pe)));
      if (grant) begin
        int rk;
        rk = 0;
        for (int l = 0; l < 2; l++) begin
          if (pe[l]) begin
            check($sformatf("rnd%0d pop_reg%0d", c, l), int'(pop_reg[l]), fl[rk]);
            if (pop_reg[l] == 6'd0) check($sformatf("rnd%0d reg0 popped", c), 0, 1);
            foreach (live[q]) if (live[q] == int'(pop_reg[l]))
              check($sformatf("rnd%0d duplicate %0d", c, live[q]), 1, 0);
            rk++;
          end
        end
      end
      step();
      if (grant) begin
        for (int l = 0; l < cnt2(pe); l++) live.push_back(fl.pop_front());
      end
      for (int l = 0; l < 2; l++) if (se[l]) fl.push_back(pr[l]);
    end
    @(negedge clk);
    check("rnd final num_free", int'(num_free), fl.size());
    check("rnd no overflow", int'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
